// File: rtl/pp_disp_pkg.sv
// Shared definitions for the pP display path.
// Contents:
//   state_t     - converter FSM states (IDLE / SHIFT / DONE)
//   BCD_W       - bits per packed BCD digit
//   min_digits  - smallest digit count D with 10^D > 2^width, used to reject
//                 converter configurations whose output cannot hold full scale
package pp_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  function automatic int min_digits(input int width);
    longint unsigned lim;
    longint unsigned pow10;
    int              d;
    lim   = longint'(1) << width;
    pow10 = 1;
    d     = 0;
    while (pow10 <= lim) begin
      pow10 = pow10 * 10;
      d     = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Handshake bundle for bcd_seq_conv.
// Producer side (master): drives in_valid/in_data/in_signed and out_ready,
// receives in_ready and the result (out_valid/out_bcd/out_neg).
// Converter side (slave): the mirror image.
// Parameters WIDTH / DIGITS must match the converter instance.
interface bcd_seq_conv_if
  import pp_disp_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic                      in_signed;
  logic                      out_valid;
  logic                      out_ready;
  logic [BCD_W*DIGITS-1:0]   out_bcd;
  logic                      out_neg;

  modport master (
    output in_valid,
    output in_data,
    output in_signed,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bcd,
    input  out_neg
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_signed,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bcd,
    output out_neg
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
// Ports:
//   din  - current BCD digit
//   dout - corrected digit (din + 3 when din >= 5, else din)
module bcd_add3_digit
  import pp_disp_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_W'(5)) begin
      dout = din + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3), one operand bit per
// cycle. Accepts an unsigned or two's-complement operand, converts its
// magnitude to DIGITS packed BCD digits and reports the sign separately.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - slave side of bcd_seq_conv_if:
//          in_valid/in_ready/in_data/in_signed  operand handshake
//          out_valid/out_ready/out_bcd/out_neg  result handshake
//          out_bcd digit 0 (ones) sits in [3:0]
module bcd_seq_conv
  import pp_disp_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  bcd_seq_conv_if.slave  bus
);

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_chk
    $error("bcd_seq_conv: WIDTH=%0d outside 2..32", WIDTH);
  end

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
    $error("bcd_seq_conv: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
           DIGITS, WIDTH, min_digits(WIDTH));
  end

  state_t                      state;
  state_t                      state_nxt;
  logic        [ACC_W-1:0]     acc;
  logic        [ACC_W-1:0]     acc_adj;
  logic        [WIDTH-1:0]     mag;
  logic        [CNT_W-1:0]     cnt;
  logic                        neg;
  logic                        neg_in;
  logic        [WIDTH-1:0]     mag_in;
  logic        [ACC_W+WIDTH-1:0] shifted;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3_digit u_add3 (
      .din  (acc[i*BCD_W +: BCD_W]),
      .dout (acc_adj[i*BCD_W +: BCD_W])
    );
  end

  // The most-negative operand negates to 2^(WIDTH-1), which still fits as an
  // unsigned WIDTH-bit magnitude, so no extra bit is needed.
  assign neg_in  = bus.in_signed & bus.in_data[WIDTH-1];
  assign mag_in  = neg_in ? (~bus.in_data + WIDTH'(1)) : bus.in_data;

  // The carry out of the top digit is dropped: the partial value in acc is
  // always below 2^WIDTH < 10^DIGITS, so it can never be set.
  assign shifted = {acc_adj, mag} << 1;

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      mag   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            neg <= neg_in;
            mag <= mag_in;
            acc <= '0;
            cnt <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          acc <= shifted[ACC_W+WIDTH-1:WIDTH];
          mag <= shifted[WIDTH-1:0];
          cnt <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers drive the outputs directly; they hold while DONE waits.
  assign bus.out_bcd = acc;
  assign bus.out_neg = neg;

endmodule

// File: tb/tb_bcd_seq_conv.sv
module tb_bcd_seq_conv;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  bcd_seq_conv_if #(.WIDTH(12), .DIGITS(4)) b12 ();
  bcd_seq_conv_if #(.WIDTH(8),  .DIGITS(3)) b8  ();

  bcd_seq_conv #(.WIDTH(12), .DIGITS(4)) dut12 (
    .clk (clk),
    .rst (rst),
    .bus (b12.slave)
  );

  bcd_seq_conv #(.WIDTH(8), .DIGITS(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    bit          s;
    logic [15:0] bcd;
    bit          neg;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decimal reference: interpret operand, take magnitude, peel decimal digits.
  task automatic ref_conv(input longint unsigned d, input bit s, input int w,
                          output logic [31:0] bcd, output bit ng);
    longint v;
    int     k;
    v = longint'(d);
    if (s && (((d >> (w - 1)) & 1) == 1)) v = v - (longint'(1) << w);
    ng = (v < 0);
    if (ng) v = -v;
    bcd = '0;
    k = 0;
    while (v > 0) begin
      bcd = bcd | (32'(v % 10) << (4 * k));
      v = v / 10;
      k++;
    end
  endtask

  // Interlock: the two sides of the handshake are never offered together.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ((b12.in_ready && b12.out_valid) || (b8.in_ready && b8.out_valid)) begin
        n_err++;
        $display("FAIL interlock: in_ready and out_valid both high at %0t", $time);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready12();
    int guard;
    guard = 0;
    while (!b12.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!b12.in_ready) check("in_ready_timeout12", 32'(b12.in_ready), 32'd1);
  endtask

  task automatic wait_valid12(output int lat);
    lat = 0;
    while (!b12.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic conv12(input logic [11:0] d, input bit s, input int hold,
                        output logic [15:0] bcd, output bit ng, output int lat);
    wait_ready12();
    @(negedge clk);
    b12.in_valid = 1'b1; b12.in_data = d; b12.in_signed = s;
    @(posedge clk); #1;
    b12.in_valid = 1'b0; b12.in_data = 12'($urandom); b12.in_signed = 1'($urandom);
    wait_valid12(lat);
    bcd = b12.out_bcd; ng = b12.out_neg;
    repeat (hold) @(posedge clk);
    @(negedge clk); b12.out_ready = 1'b1;
    @(posedge clk); #1; b12.out_ready = 1'b0;
  endtask

  task automatic conv8(input logic [7:0] d, input bit s,
                       output logic [11:0] bcd, output bit ng, output int lat);
    int guard;
    guard = 0;
    while (!b8.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(negedge clk);
    b8.in_valid = 1'b1; b8.in_data = d; b8.in_signed = s;
    @(posedge clk); #1;
    b8.in_valid = 1'b0; b8.in_data = 8'($urandom); b8.in_signed = 1'($urandom);
    lat = 0;
    while (!b8.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    bcd = b8.out_bcd; ng = b8.out_neg;
    @(negedge clk); b8.out_ready = 1'b1;
    @(posedge clk); #1; b8.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] bcd;
    logic [11:0] bcd8;
    logic [31:0] eb;
    bit          ng;
    bit          en;
    int          lat;
    bit          stale;

    n_cmp = 0;
    n_err = 0;

    vecs[0]  = '{12'hFFF, 1'b0, 16'h4095, 1'b0};
    vecs[1]  = '{12'hFFF, 1'b1, 16'h0001, 1'b1};
    vecs[2]  = '{12'h800, 1'b1, 16'h2048, 1'b1};
    vecs[3]  = '{12'h000, 1'b1, 16'h0000, 1'b0};
    vecs[4]  = '{12'h7FF, 1'b1, 16'h2047, 1'b0};
    vecs[5]  = '{12'h000, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{12'h800, 1'b0, 16'h2048, 1'b0};
    vecs[7]  = '{12'h001, 1'b1, 16'h0001, 1'b0};
    vecs[8]  = '{12'hFFE, 1'b1, 16'h0002, 1'b1};
    vecs[9]  = '{12'h3E7, 1'b0, 16'h0999, 1'b0};
    vecs[10] = '{12'h801, 1'b1, 16'h2047, 1'b1};
    vecs[11] = '{12'hC18, 1'b1, 16'h1000, 1'b1};

    rst = 1'b1;
    b12.in_valid = 1'b0; b12.in_data = '0; b12.in_signed = 1'b0; b12.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_signed  = 1'b0; b8.out_ready  = 1'b0;
    #1;
    check("rst_in_ready",  32'(b12.in_ready),  32'd1);
    check("rst_out_valid", 32'(b12.out_valid), 32'd0);
    check("rst_out_bcd",   32'(b12.out_bcd),   32'd0);
    check("rst_out_neg",   32'(b12.out_neg),   32'd0);
    check("rst8_out_bcd",  32'(b8.out_bcd),    32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      conv12(vecs[i].d, vecs[i].s, i % 3, bcd, ng, lat);
      check($sformatf("vec%0d_bcd", i), 32'(bcd), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_neg", i), 32'(ng),  32'(vecs[i].neg));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd12);
    end

    // Backpressure: result held 5 cycles; in_valid during DONE is ignored.
    wait_ready12();
    @(negedge clk);
    b12.in_valid = 1'b1; b12.in_data = 12'h7FF; b12.in_signed = 1'b1;
    @(posedge clk); #1;
    b12.in_valid = 1'b0;
    wait_valid12(lat);
    check("bp_lat", 32'(lat), 32'd12);
    b12.in_valid = 1'b1; b12.in_data = 12'h555; b12.in_signed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", i), 32'(b12.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_bcd", i),   32'(b12.out_bcd),   32'h2047);
      check($sformatf("bp_hold%0d_neg", i),   32'(b12.out_neg),   32'd0);
      check($sformatf("bp_hold%0d_rdy", i),   32'(b12.in_ready),  32'd0);
    end
    @(negedge clk);
    b12.out_ready = 1'b1; b12.in_data = 12'h123;
    @(posedge clk); #1;
    b12.out_ready = 1'b0;
    check("bp_release_valid", 32'(b12.out_valid), 32'd0);
    check("bp_release_rdy",   32'(b12.in_ready),  32'd1);
    @(posedge clk); #1;
    check("bp_accept_rdy", 32'(b12.in_ready), 32'd0);
    b12.in_valid = 1'b0;
    wait_valid12(lat);
    check("bp_next_lat", 32'(lat),          32'd12);
    check("bp_next_bcd", 32'(b12.out_bcd),  32'h0291);
    check("bp_next_neg", 32'(b12.out_neg),  32'd0);
    @(negedge clk); b12.out_ready = 1'b1;
    @(posedge clk); #1; b12.out_ready = 1'b0;

    // out_ready held high through the conversion has no effect until DONE.
    wait_ready12();
    @(negedge clk);
    b12.in_valid = 1'b1; b12.in_data = 12'h0FF; b12.in_signed = 1'b0; b12.out_ready = 1'b1;
    @(posedge clk); #1;
    b12.in_valid = 1'b0;
    wait_valid12(lat);
    check("early_rdy_lat", 32'(lat),         32'd12);
    check("early_rdy_bcd", 32'(b12.out_bcd), 32'h0255);
    @(posedge clk); #1;
    check("early_rdy_consumed", 32'(b12.out_valid), 32'd0);
    b12.out_ready = 1'b0;

    // Asynchronous reset during SHIFT.
    wait_ready12();
    @(negedge clk);
    b12.in_valid = 1'b1; b12.in_data = 12'hFFF; b12.in_signed = 1'b0;
    @(posedge clk); #1;
    b12.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_shift_bcd",   32'(b12.out_bcd),   32'd0);
    check("rst_shift_neg",   32'(b12.out_neg),   32'd0);
    check("rst_shift_valid", 32'(b12.out_valid), 32'd0);
    check("rst_shift_rdy",   32'(b12.in_ready),  32'd1);
    @(negedge clk); rst = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b12.out_valid) stale = 1'b1;
    end
    check("rst_shift_no_stale", 32'(stale), 32'd0);
    check("rst_shift_rdy_after", 32'(b12.in_ready), 32'd1);

    // Asynchronous reset while a negative result waits in DONE.
    @(negedge clk);
    b12.in_valid = 1'b1; b12.in_data = 12'hFFF; b12.in_signed = 1'b1;
    @(posedge clk); #1;
    b12.in_valid = 1'b0;
    wait_valid12(lat);
    check("pre_rst_done_neg", 32'(b12.out_neg), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_done_neg",   32'(b12.out_neg),   32'd0);
    check("rst_done_bcd",   32'(b12.out_bcd),   32'd0);
    check("rst_done_valid", 32'(b12.out_valid), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_done_rdy_after", 32'(b12.in_ready), 32'd1);

    // Randomized operands against the decimal reference.
    for (int i = 0; i < 150; i++) begin
      logic [11:0] d;
      bit          s;
      case (i % 10)
        0:       d = 12'h800;
        1:       d = 12'hFFF;
        default: d = 12'($urandom_range(0, 4095));
      endcase
      s = 1'($urandom_range(0, 1));
      conv12(d, s, $urandom_range(0, 3), bcd, ng, lat);
      ref_conv(longint'(d), s, 12, eb, en);
      check($sformatf("rnd%0d_%h_%0d_bcd", i, d, s), 32'(bcd), eb);
      check($sformatf("rnd%0d_%h_%0d_neg", i, d, s), 32'(ng),  32'(en));
      check($sformatf("rnd%0d_lat", i),             32'(lat), 32'd12);
    end

    // WIDTH=8 / DIGITS=3 instance.
    conv8(8'h80, 1'b1, bcd8, ng, lat);
    check("w8_most_neg_bcd", 32'(bcd8), 32'h128);
    check("w8_most_neg_neg", 32'(ng),   32'd1);
    check("w8_lat",          32'(lat),  32'd8);
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 256; v++) begin
        conv8(8'(v), 1'(s), bcd8, ng, lat);
        ref_conv(longint'(v), 1'(s), 8, eb, en);
        check($sformatf("w8_sweep_%0d_%h", s, v), {19'd0, ng, bcd8}, {19'd0, en, eb[11:0]});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
